// File: rtl/spi_controller_if.sv
// Request/response bundle between a requester (test/loopback logic, bring-up
// sequencer) and spi_controller.
`default_nettype none

interface spi_controller_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       done;
    logic [7:0] rdata;
    logic       busy;

    modport master (
        output req_valid, req_rw, req_addr, req_data,
        input  req_ready, done, rdata, busy
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_data,
        output req_ready, done, rdata, busy
    );
endinterface

`default_nettype wire

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: each accepted request becomes one 16-bit MSB-first
// frame {rw, addr, data}; cipo is captured and its low byte returned as rdata.
`default_nettype none

module spi_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_controller_if.slave bus,
    output logic            sclk,
    output logic            ncs,
    output logic            copi,
    input  logic            cipo
);

    localparam int PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TMR_MAX = (CS_SETUP > CS_HOLD)
                           ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                           : ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD - 1);
    localparam logic [TMR_W-1:0] IDLE_LAST  = TMR_W'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_t;

    state_t            state_reg, state_next;
    logic [TMR_W-1:0]  tmr_reg, tmr_next;
    logic [PH_W-1:0]   phase_reg, phase_next;
    logic [3:0]        bit_reg, bit_next;
    logic [15:0]       shift_reg, shift_next;
    // Only the last eight of the sixteen cipo samples are ever reported.
    logic [7:0]        cap_reg, cap_next;
    logic              sclk_reg, sclk_next;
    logic              ncs_reg, ncs_next;
    logic              copi_reg, copi_next;
    logic              done_reg, done_next;
    logic              busy_reg, busy_next;
    logic              ready_reg, ready_next;
    logic [7:0]        rdata_reg, rdata_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            tmr_reg   <= '0;
            phase_reg <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            cap_reg   <= '0;
            sclk_reg  <= 1'b0;
            ncs_reg   <= 1'b1;
            copi_reg  <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            tmr_reg   <= tmr_next;
            phase_reg <= phase_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            cap_reg   <= cap_next;
            sclk_reg  <= sclk_next;
            ncs_reg   <= ncs_next;
            copi_reg  <= copi_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
            ready_reg <= ready_next;
            rdata_reg <= rdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tmr_next   = tmr_reg;
        phase_next = phase_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        cap_next   = cap_reg;
        sclk_next  = sclk_reg;
        ncs_next   = ncs_reg;
        copi_next  = copi_reg;
        done_next  = 1'b0;
        busy_next  = busy_reg;
        ready_next = ready_reg;
        rdata_next = rdata_reg;

        case (state_reg)
            IDLE: begin
                if (ready_reg && bus.req_valid) begin
                    state_next = SETUP;
                    shift_next = {bus.req_rw, bus.req_addr, bus.req_data};
                    copi_next  = bus.req_rw;
                    ncs_next   = 1'b0;
                    busy_next  = 1'b1;
                    ready_next = 1'b0;
                    tmr_next   = '0;
                end
            end
            SETUP: begin
                if (tmr_reg == SETUP_LAST) begin
                    state_next = XFER;
                    phase_next = '0;
                    bit_next   = '0;
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
            end
            XFER: begin
                if (phase_reg == PH_LAST) begin
                    phase_next = '0;
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                        cap_next  = {cap_reg[6:0], cipo};
                    end else begin
                        sclk_next = 1'b0;
                        if (bit_reg == 4'd15) begin
                            state_next = HOLD;
                            tmr_next   = '0;
                        end else begin
                            // Next bit goes out on the falling edge, a full half-period before its rise.
                            bit_next   = bit_reg + 1'b1;
                            copi_next  = shift_reg[14];
                            shift_next = shift_reg << 1;
                        end
                    end
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            HOLD: begin
                if (tmr_reg == HOLD_LAST) begin
                    state_next = GAP;
                    ncs_next   = 1'b1;
                    copi_next  = 1'b0;
                    done_next  = 1'b1;
                    rdata_next = cap_reg;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
            end
            GAP: begin
                if (tmr_reg == IDLE_LAST) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    ready_next = 1'b1;
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sclk          = sclk_reg;
    assign ncs           = ncs_reg;
    assign copi          = copi_reg;
    assign bus.req_ready = ready_reg;
    assign bus.done      = done_reg;
    assign bus.busy      = busy_reg;
    assign bus.rdata     = rdata_reg;

endmodule

`default_nettype wire

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a default-timing instance (A) and a minimum-timing
// instance (B), checked against frames decoded from the SPI pins.
`timescale 1ns/1ps

module tb_spi_controller;

    localparam int A_DIV = 4, A_SETUP = 4, A_HOLD = 4, A_IDLE = 8;
    localparam int B_DIV = 1, B_SETUP = 1, B_HOLD = 1, B_IDLE = 1;
    localparam int A_LOW = A_SETUP + 32 * A_DIV + A_HOLD;
    localparam int B_LOW = B_SETUP + 32 * B_DIV + B_HOLD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_controller_if ifa ();
    spi_controller_if ifb ();
    logic sclk_a, ncs_a, copi_a, cipo_a;
    logic sclk_b, ncs_b, copi_b, cipo_b;

    spi_controller #(.CLK_DIV(A_DIV), .CS_SETUP(A_SETUP), .CS_HOLD(A_HOLD), .CS_IDLE(A_IDLE)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa),
        .sclk(sclk_a), .ncs(ncs_a), .copi(copi_a), .cipo(cipo_a)
    );

    spi_controller #(.CLK_DIV(B_DIV), .CS_SETUP(B_SETUP), .CS_HOLD(B_HOLD), .CS_IDLE(B_IDLE)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb),
        .sclk(sclk_b), .ncs(ncs_b), .copi(copi_b), .cipo(cipo_b)
    );

    // Pin-level frame decoder state, index 0 = instance A, 1 = instance B.
    logic [15:0] m_word [2];
    int          m_rises [2], m_low [2], m_frames [2], m_dones [2];
    int          m_rise_cyc [2], m_gap [2], m_busy_fall [2], m_glitch [2];
    logic [7:0]  m_rdata_done [2];
    logic [15:0] f_word [2];
    int          f_rises [2], f_low [2];
    logic        p_sclk [2], p_ncs [2], p_copi [2], p_busy [2];
    logic        loop_mode [2];
    logic [15:0] resp [2];
    logic [15:0] wq0 [$];
    logic [15:0] wq1 [$];

    always @(negedge clk) begin : monitor
        logic       s_v [2];
        logic       n_v [2];
        logic       c_v [2];
        logic       d_v [2];
        logic       b_v [2];
        logic [7:0] r_v [2];
        s_v[0] = sclk_a; n_v[0] = ncs_a; c_v[0] = copi_a; d_v[0] = ifa.done; b_v[0] = ifa.busy; r_v[0] = ifa.rdata;
        s_v[1] = sclk_b; n_v[1] = ncs_b; c_v[1] = copi_b; d_v[1] = ifb.done; b_v[1] = ifb.busy; r_v[1] = ifb.rdata;
        for (int k = 0; k < 2; k++) begin
            if (n_v[k] === 1'b0) begin
                if (p_ncs[k]) begin
                    m_rises[k] = 0;
                    m_low[k]   = 0;
                    m_word[k]  = '0;
                    m_gap[k]   = cyc - m_rise_cyc[k];
                end
                m_low[k]++;
                if (s_v[k] && !p_sclk[k]) begin
                    m_word[k] = {m_word[k][14:0], c_v[k]};
                    m_rises[k]++;
                end
                if (s_v[k] && p_sclk[k] && (c_v[k] !== p_copi[k])) m_glitch[k]++;
            end else if (!p_ncs[k]) begin
                f_word[k]     = m_word[k];
                f_rises[k]    = m_rises[k];
                f_low[k]      = m_low[k];
                m_rise_cyc[k] = cyc;
                m_frames[k]++;
                if (k == 0) wq0.push_back(m_word[k]);
                else        wq1.push_back(m_word[k]);
            end
            if (n_v[k] && s_v[k]) m_glitch[k]++;
            if (d_v[k] === 1'b1) begin
                m_dones[k]++;
                m_rdata_done[k] = r_v[k];
            end
            if (p_busy[k] && !b_v[k]) m_busy_fall[k] = cyc;
            p_sclk[k] = s_v[k];
            p_ncs[k]  = n_v[k];
            p_copi[k] = c_v[k];
            p_busy[k] = b_v[k];
        end
        // Peripheral model: present response bit (15 - rises) ahead of each sclk rise.
        cipo_a = loop_mode[0] ? copi_a : ((m_rises[0] < 16) ? resp[0][15 - m_rises[0]] : 1'b0);
        cipo_b = loop_mode[1] ? copi_b : ((m_rises[1] < 16) ? resp[1][15 - m_rises[1]] : 1'b0);
    end

    task automatic tick_n();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [15:0] w);
        if (k == 0) begin
            ifa.req_valid = v; ifa.req_rw = w[15]; ifa.req_addr = w[14:8]; ifa.req_data = w[7:0];
        end else begin
            ifb.req_valid = v; ifb.req_rw = w[15]; ifb.req_addr = w[14:8]; ifb.req_data = w[7:0];
        end
    endtask

    function automatic logic ready_of(input int k);
        return (k == 0) ? ifa.req_ready : ifb.req_ready;
    endfunction

    task automatic send(input int k, input logic [15:0] w, output bit ok);
        int n = 0;
        set_req(k, 1'b1, w);
        while (ready_of(k) !== 1'b1 && n < 1000) begin
            tick_n();
            n++;
        end
        tick_n();
        set_req(k, 1'b0, w);
        ok = (n < 1000);
    endtask

    task automatic wait_frames(input int k, input int target, output bit ok);
        int n = 0;
        while (m_frames[k] < target && n < 2000) begin
            tick_n();
            n++;
        end
        ok = (m_frames[k] >= target);
    endtask

    task automatic test_reset();
        repeat (3) tick_n();
        checks++; if (ncs_a !== 1'b1) begin failures++; $display("FAIL reset_ncs got=%b exp=1", ncs_a); end
        checks++; if (sclk_a !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk_a); end
        checks++; if (copi_a !== 1'b0) begin failures++; $display("FAIL reset_copi got=%b exp=0", copi_a); end
        checks++; if ({ifa.done, ifa.busy} !== 2'b00) begin failures++; $display("FAIL reset_done_busy got=%b exp=00", {ifa.done, ifa.busy}); end
        checks++; if (ifa.rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", ifa.rdata); end
        checks++; if (ifa.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ifa.req_ready); end
        checks++; if (ncs_b !== 1'b1) begin failures++; $display("FAIL reset_ncs_b got=%b exp=1", ncs_b); end
        rst_n = 1'b1;
        repeat (3) tick_n();
        checks++; if ({ifa.req_ready, ncs_a} !== 2'b11) begin failures++; $display("FAIL idle_after_reset got=%b exp=11", {ifa.req_ready, ncs_a}); end
    endtask

    task automatic test_write_frame(input int k);
        bit          ok;
        int          fr0 = m_frames[k];
        int          d0  = m_dones[k];
        int          g0  = m_glitch[k];
        int          exp_low = (k == 0) ? A_LOW : B_LOW;
        logic [15:0] r = 16'($urandom);
        loop_mode[k] = 1'b0;
        resp[k] = r;
        send(k, 16'h80A5, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wr%0d_accept got=timeout exp=accepted", k); end
        if (k == 0) begin
            checks++; if ({ncs_a, ifa.busy, copi_a, ifa.req_ready} !== 4'b0110) begin
                failures++; $display("FAIL wr_first_cycle ncs/busy/copi/ready got=%b exp=0110", {ncs_a, ifa.busy, copi_a, ifa.req_ready});
            end
        end
        wait_frames(k, fr0 + 1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wr%0d_frame got=timeout exp=frame", k); end
        checks++; if (f_word[k] !== 16'h80A5) begin failures++; $display("FAIL wr%0d_word got=%h exp=80a5", k, f_word[k]); end
        checks++; if (f_rises[k] !== 16) begin failures++; $display("FAIL wr%0d_rises got=%0d exp=16", k, f_rises[k]); end
        checks++; if (f_low[k] !== exp_low) begin failures++; $display("FAIL wr%0d_ncs_low got=%0d exp=%0d", k, f_low[k], exp_low); end
        checks++; if (m_rdata_done[k] !== r[7:0]) begin failures++; $display("FAIL wr%0d_rdata got=%h exp=%h", k, m_rdata_done[k], r[7:0]); end
        checks++; if (m_glitch[k] !== g0) begin failures++; $display("FAIL wr%0d_copi_stable got=%0d exp=0", k, m_glitch[k] - g0); end
        repeat (A_IDLE + 4) tick_n();
        checks++; if (m_dones[k] - d0 !== 1) begin failures++; $display("FAIL wr%0d_done_pulses got=%0d exp=1", k, m_dones[k] - d0); end
        $display("txn inst=%0d word=80a5 rises=%0d ncs_low=%0d", k, f_rises[k], f_low[k]);
    endtask

    task automatic test_loopback_read();
        bit ok;
        int fr0 = m_frames[0];
        loop_mode[0] = 1'b1;
        send(0, 16'h043C, ok);
        checks++; if (!ok) begin failures++; $display("FAIL lb_accept got=timeout exp=accepted"); end
        wait_frames(0, fr0 + 1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL lb_frame got=timeout exp=frame"); end
        checks++; if (f_word[0] !== 16'h043C) begin failures++; $display("FAIL lb_word got=%h exp=043c", f_word[0]); end
        checks++; if (m_rdata_done[0] !== 8'h3C) begin failures++; $display("FAIL lb_rdata_at_done got=%h exp=3c", m_rdata_done[0]); end
        repeat (A_IDLE + 3) tick_n();
        checks++; if (ifa.rdata !== 8'h3C) begin failures++; $display("FAIL lb_rdata_hold got=%h exp=3c", ifa.rdata); end
        checks++; if (m_busy_fall[0] - m_rise_cyc[0] !== A_IDLE) begin
            failures++; $display("FAIL lb_busy_tail got=%0d exp=%0d", m_busy_fall[0] - m_rise_cyc[0], A_IDLE);
        end
        loop_mode[0] = 1'b0;
        $display("txn inst=0 word=%h rdata=%h", f_word[0], ifa.rdata);
    endtask

    task automatic test_back_to_back();
        bit          ok;
        int          n;
        int          fr0 = m_frames[0];
        logic [15:0] w1 = 16'($urandom);
        logic [15:0] w2 = 16'($urandom);
        wq0.delete();
        set_req(0, 1'b1, w1);
        n = 0;
        while (ifa.req_ready !== 1'b1 && n < 1000) begin tick_n(); n++; end
        tick_n();
        set_req(0, 1'b1, ~w1);
        repeat (40) tick_n();
        checks++; if (ifa.req_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_midframe got=%b exp=0", ifa.req_ready); end
        set_req(0, 1'b1, w2);
        n = 0;
        while (ifa.req_ready !== 1'b1 && n < 1000) begin tick_n(); n++; end
        tick_n();
        set_req(0, 1'b0, w2);
        checks++; if (n >= 1000) begin failures++; $display("FAIL b2b_second_accept got=timeout exp=accepted"); end
        wait_frames(0, fr0 + 2, ok);
        checks++; if (wq0.size() !== 2) begin
            failures++; $display("FAIL b2b_frames got=%0d exp=2", wq0.size());
        end else begin
            checks++; if (wq0[0] !== w1) begin failures++; $display("FAIL b2b_word1 got=%h exp=%h", wq0[0], w1); end
            checks++; if (wq0[1] !== w2) begin failures++; $display("FAIL b2b_word2 got=%h exp=%h", wq0[1], w2); end
        end
        checks++; if (m_gap[0] !== A_IDLE + 1) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", m_gap[0], A_IDLE + 1); end
        $display("txn inst=0 b2b w1=%h w2=%h gap=%0d", w1, w2, m_gap[0]);
    endtask

    task automatic test_random(input int k, input int count);
        bit          ok;
        int          fr0;
        logic [15:0] w, r;
        int          exp_low  = (k == 0) ? A_LOW : B_LOW;
        int          exp_gap  = ((k == 0) ? A_IDLE : B_IDLE) + 1;
        loop_mode[k] = 1'b0;
        for (int i = 0; i < count; i++) begin
            w = 16'($urandom);
            r = 16'($urandom);
            resp[k] = r;
            fr0 = m_frames[k];
            send(k, w, ok);
            wait_frames(k, fr0 + 1, ok);
            checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_frame got=timeout exp=frame", k); end
            checks++; if (f_word[k] !== w) begin failures++; $display("FAIL rnd%0d_word got=%h exp=%h", k, f_word[k], w); end
            checks++; if (m_rdata_done[k] !== r[7:0]) begin failures++; $display("FAIL rnd%0d_rdata got=%h exp=%h", k, m_rdata_done[k], r[7:0]); end
            checks++; if (f_low[k] !== exp_low) begin failures++; $display("FAIL rnd%0d_ncs_low got=%0d exp=%0d", k, f_low[k], exp_low); end
            if (i > 0) begin
                checks++; if (m_gap[k] !== exp_gap) begin failures++; $display("FAIL rnd%0d_gap got=%0d exp=%0d", k, m_gap[k], exp_gap); end
            end
            $display("txn inst=%0d word=%h rdata=%h gap=%0d", k, f_word[k], m_rdata_done[k], m_gap[k]);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int n = 0;
        int d0 = m_dones[0];
        send(0, 16'($urandom), ok);
        while (m_rises[0] < 8 && n < 1000) begin tick_n(); n++; end
        checks++; if (n >= 1000) begin failures++; $display("FAIL rst_reach_bit7 got=timeout exp=bit7"); end
        rst_n = 1'b0;
        #1;
        checks++; if ({ncs_a, sclk_a, copi_a} !== 3'b100) begin failures++; $display("FAIL rst_pins ncs/sclk/copi got=%b exp=100", {ncs_a, sclk_a, copi_a}); end
        checks++; if ({ifa.busy, ifa.req_ready} !== 2'b01) begin failures++; $display("FAIL rst_busy_ready got=%b exp=01", {ifa.busy, ifa.req_ready}); end
        repeat (2) tick_n();
        rst_n = 1'b1;
        repeat (200) tick_n();
        checks++; if (m_dones[0] !== d0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", m_dones[0] - d0); end
        checks++; if (ifa.rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata got=%h exp=00", ifa.rdata); end
        checks++; if ({ifa.req_ready, ncs_a} !== 2'b11) begin failures++; $display("FAIL rst_idle_after got=%b exp=11", {ifa.req_ready, ncs_a}); end
        $display("txn inst=0 aborted at bit period 7");
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            p_sclk[k] = 1'b0; p_ncs[k] = 1'b1; p_copi[k] = 1'b0; p_busy[k] = 1'b0;
            loop_mode[k] = 1'b0; resp[k] = '0; m_word[k] = '0; f_word[k] = '0;
            m_rdata_done[k] = '0;
        end
        cipo_a = 1'b0;
        cipo_b = 1'b0;
        set_req(0, 1'b0, 16'h0000);
        set_req(1, 1'b0, 16'h0000);

        test_reset();
        test_write_frame(0);
        test_loopback_read();
        test_back_to_back();
        test_write_frame(1);
        test_random(0, 6);
        test_random(1, 12);
        test_reset_midframe();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
